beam_trigger_scaler: RTL and testbench

//  Per-beam trigger scaler for the L1 beamformed trigger path, running on the trigger clock.

---
 rtl/beam_trigger_scaler.sv | 189 ++++++++++++++++++
 tb/tb_beam_trigger_scaler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beam_trigger_scaler.sv
// beam_trigger_scaler
//   Per-beam trigger scaler on the trigger clock. Each raw beam trigger goes
//   through a holdoff that can be changed at runtime. The qualified triggers
//   are counted over a programmable gate, in single-shot or continuous mode.
//   Saturating live counters are copied into a result bank at the end of
//   each gate. A registered read port serves the result bank.
//
// Ports
//   clk_i        trigger clock; all logic on the rising edge
//   rst_i        asynchronous, active-high reset
//   trig_i       raw per-beam trigger levels
//   trig_o       holdoff-qualified triggers (combinational from trig_i)
//   holdoff_i    holdoff length in cycles; applies live to all beams
//   period_i     gate length in cycles, sampled on start_i (0 acts as 1)
//   cont_i       1 = continuous gates, 0 = single shot; sampled on start_i
//   start_i      pulse: (re)start gating; wins over abort_i and over a snapshot
//   abort_i      pulse: return to idle, result bank untouched
//   busy_o       high while the gate FSM is not idle
//   done_o       one-cycle pulse in the cycle after the result bank updates
//   rd_stb_i     read request
//   rd_beam_i    beam index to read; out-of-range indices read as zero
//   rd_ack_o     read acknowledge, exactly one cycle after rd_stb_i
//   rd_dat_o     result count; valid with rd_ack_o, held until the next ack
//   rd_sat_o     result saturation flag; valid with rd_ack_o
//   dbg_state_o  current gate FSM state (IDLE=0, COUNT=1, SNAP=2)
//
// Read handshake: rd_stb_i has no ready. Every cycle with rd_stb_i high is
// one request, back-to-back included. Each request gets exactly one
// rd_ack_o pulse on the following cycle. rd_dat_o/rd_sat_o change only
// together with rd_ack_o.

module beam_trigger_scaler #(
  parameter int NBEAMS       = 2,
  parameter int COUNT_BITS   = 32,
  parameter int PERIOD_BITS  = 32,
  parameter int HOLDOFF_BITS = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NBEAMS-1:0]       trig_i,
  output logic [NBEAMS-1:0]       trig_o,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  input  logic [PERIOD_BITS-1:0]  period_i,
  input  logic                    cont_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  output logic                    busy_o,
  output logic                    done_o,
  input  logic                    rd_stb_i,
  input  logic [7:0]              rd_beam_i,
  output logic                    rd_ack_o,
  output logic [COUNT_BITS-1:0]   rd_dat_o,
  output logic                    rd_sat_o,
  output logic [1:0]              dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_SNAP  = 2'd2
  } state_t;

  localparam int IDX_W = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;
  localparam logic [COUNT_BITS-1:0]   CNT_MAX    = '1;
  localparam logic [COUNT_BITS-1:0]   CNT_ONE    = 1;
  localparam logic [PERIOD_BITS-1:0]  PERIOD_ONE = 1;
  localparam logic [HOLDOFF_BITS-1:0] HOLD_ONE   = 1;

  state_t                  state;
  logic [PERIOD_BITS-1:0]  period_q;
  logic [PERIOD_BITS-1:0]  timer;
  logic                    cont_q;
  logic [COUNT_BITS-1:0]   live_cnt [NBEAMS];
  logic [COUNT_BITS-1:0]   result   [NBEAMS];
  logic [NBEAMS-1:0]       live_sat;
  logic [NBEAMS-1:0]       res_sat;
  logic [HOLDOFF_BITS-1:0] hold_cnt [NBEAMS];
  logic [IDX_W-1:0]        rd_idx;
  logic                    rd_in_range;

  assign busy_o      = (state != S_IDLE);
  assign dbg_state_o = state;

  // Holdoff: a beam qualifies only when its timer has run out. The timer
  // reloads on every qualified trigger, so holdoff H gives a spacing of H+1.
  always_comb begin
    trig_o = '0;
    for (int b = 0; b < NBEAMS; b++) begin
      trig_o[b] = trig_i[b] & (hold_cnt[b] == '0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < NBEAMS; b++) hold_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < NBEAMS; b++) begin
        if (trig_o[b]) begin
          hold_cnt[b] <= holdoff_i;
        end else if (hold_cnt[b] != '0) begin
          hold_cnt[b] <= hold_cnt[b] - HOLD_ONE;
        end
      end
    end
  end

  // Gate FSM with the live counters and the result bank. SNAP is a single
  // dead-time cycle: no triggers are counted while the bank is loaded.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      period_q <= PERIOD_ONE;
      timer    <= '0;
      cont_q   <= 1'b0;
      live_sat <= '0;
      res_sat  <= '0;
      done_o   <= 1'b0;
      for (int b = 0; b < NBEAMS; b++) begin
        live_cnt[b] <= '0;
        result[b]   <= '0;
      end
    end else begin
      done_o <= 1'b0;
      if (start_i) begin
        state    <= S_COUNT;
        period_q <= (period_i == '0) ? PERIOD_ONE : period_i;
        cont_q   <= cont_i;
        timer    <= '0;
        live_sat <= '0;
        for (int b = 0; b < NBEAMS; b++) live_cnt[b] <= '0;
      end else if (abort_i) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_COUNT: begin
            for (int b = 0; b < NBEAMS; b++) begin
              if (trig_o[b]) begin
                if (live_cnt[b] == CNT_MAX) live_sat[b] <= 1'b1;
                else                        live_cnt[b] <= live_cnt[b] + CNT_ONE;
              end
            end
            // The last gate cycle is still counted before moving to SNAP.
            if (timer == period_q - PERIOD_ONE) state <= S_SNAP;
            else                                timer <= timer + PERIOD_ONE;
          end
          S_SNAP: begin
            res_sat <= live_sat;
            done_o  <= 1'b1;
            for (int b = 0; b < NBEAMS; b++) result[b] <= live_cnt[b];
            if (cont_q) begin
              state    <= S_COUNT;
              timer    <= '0;
              live_sat <= '0;
              for (int b = 0; b < NBEAMS; b++) live_cnt[b] <= '0;
            end else begin
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Read port. A read in the SNAP cycle samples the bank on the same edge that
  // loads it, so it returns the pre-snapshot contents.
  assign rd_idx      = rd_beam_i[IDX_W-1:0];
  assign rd_in_range = ({1'b0, rd_beam_i} < 9'(NBEAMS));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ack_o <= 1'b0;
      rd_dat_o <= '0;
      rd_sat_o <= 1'b0;
    end else begin
      rd_ack_o <= rd_stb_i;
      if (rd_stb_i) begin
        if (rd_in_range) begin
          rd_dat_o <= result[rd_idx];
          rd_sat_o <= res_sat[rd_idx];
        end else begin
          rd_dat_o <= '0;
          rd_sat_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_beam_trigger_scaler.sv
module tb_beam_trigger_scaler;
  localparam int NB   = 2;
  localparam int CB   = 4;
  localparam int PB   = 32;
  localparam int HB   = 8;
  localparam int CMAX = (1 << CB) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [NB-1:0] trig_i = '0;
  logic [NB-1:0] trig_o;
  logic [HB-1:0] holdoff_i = '0;
  logic [PB-1:0] period_i = '0;
  logic          cont_i = 1'b0, start_i = 1'b0, abort_i = 1'b0;
  logic          busy_o, done_o;
  logic          rd_stb_i = 1'b0;
  logic [7:0]    rd_beam_i = '0;
  logic          rd_ack_o;
  logic [CB-1:0] rd_dat_o;
  logic          rd_sat_o;
  logic [1:0]    dbg_state_o;

  always #5 clk = ~clk;

  beam_trigger_scaler #(
    .NBEAMS(NB), .COUNT_BITS(CB), .PERIOD_BITS(PB), .HOLDOFF_BITS(HB)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .trig_i(trig_i), .trig_o(trig_o),
    .holdoff_i(holdoff_i), .period_i(period_i), .cont_i(cont_i),
    .start_i(start_i), .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
    .rd_stb_i(rd_stb_i), .rd_beam_i(rd_beam_i), .rd_ack_o(rd_ack_o),
    .rd_dat_o(rd_dat_o), .rd_sat_o(rd_sat_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [CB:0] exp_q[$];
  logic [CB:0] held = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Time based: a trigger qualifies if it comes more than the holdoff (as it
  // was when the previous qualified trigger happened) after that trigger.
  // The gate is a repeating frame of per+1 cycles counted from the start edge:
  // positions 1..per count triggers, position per+1 is the snapshot.
  longint      cyc = 0;
  longint      last_t [NB];
  int          h_at   [NB];
  bit          has_last [NB];
  bit          active, mcont, m_ack, m_done;
  longint      gs, per;
  int          mcnt [NB];
  bit          msat [NB];
  logic [CB-1:0] bank [NB];
  bit          bsat [NB];
  logic [NB-1:0] q_now;
  logic        obs_done, obs_ack, obs_sat;
  logic [CB-1:0] obs_dat;

  task automatic model_reset();
    active = 0; mcont = 0; m_ack = 0; m_done = 0; gs = 0; per = 1;
    for (int b = 0; b < NB; b++) begin
      has_last[b] = 0; last_t[b] = 0; h_at[b] = 0;
      mcnt[b] = 0; msat[b] = 0; bank[b] = '0; bsat[b] = 0;
    end
    exp_q.delete();
    held = '0;
  endtask

  task automatic model_edge();
    longint pos, k;
    for (int b = 0; b < NB; b++) begin
      if (q_now[b]) begin
        last_t[b] = cyc; h_at[b] = int'(holdoff_i); has_last[b] = 1;
      end
    end
    m_ack = rd_stb_i;
    if (rd_stb_i) begin
      if (rd_beam_i < NB) exp_q.push_back({bsat[rd_beam_i], bank[rd_beam_i]});
      else                exp_q.push_back('0);
    end
    m_done = 0;
    if (start_i) begin
      active = 1; gs = cyc; per = (period_i == 0) ? 1 : longint'(period_i);
      mcont = cont_i;
      for (int b = 0; b < NB; b++) begin mcnt[b] = 0; msat[b] = 0; end
    end else if (abort_i) begin
      active = 0;
    end else if (active) begin
      pos = cyc - gs;
      k = (pos - 1) % (per + 1);
      if (k < per) begin
        for (int b = 0; b < NB; b++)
          if (q_now[b]) begin
            if (mcnt[b] == CMAX) msat[b] = 1;
            else                 mcnt[b]++;
          end
      end else begin
        for (int b = 0; b < NB; b++) begin
          bank[b] = CB'(mcnt[b]); bsat[b] = msat[b]; mcnt[b] = 0; msat[b] = 0;
        end
        m_done = 1;
        if (!mcont) active = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    for (int b = 0; b < NB; b++)
      q_now[b] = trig_i[b] && (!has_last[b] || (cyc - last_t[b]) > h_at[b]);
    chk("trig_o", trig_o, q_now);
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("busy", busy_o, active);
    chk("done", done_o, m_done);
    chk("rd_ack", rd_ack_o, m_ack);
    if (rd_ack_o) begin
      chk("rd_queue", exp_q.size(), 1);
      if (exp_q.size() > 0) held = exp_q.pop_front();
    end
    chk("rd_data", {rd_sat_o, rd_dat_o}, held);
    obs_done = done_o; obs_ack = rd_ack_o; obs_dat = rd_dat_o; obs_sat = rd_sat_o;
  endtask

  task automatic do_reset();
    start_i = 0; abort_i = 0; trig_i = '0; rd_stb_i = 0;
    rst_i = 1;
    #2;
    model_reset();
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ack", rd_ack_o, 0);
    chk("rst_dat", {rd_sat_o, rd_dat_o}, 0);
    chk("rst_state", dbg_state_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_i = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int beam, output logic [CB-1:0] d, output logic s);
    rd_stb_i = 1; rd_beam_i = 8'(beam);
    step();
    rd_stb_i = 0;
    chk("read_ack", obs_ack, 1);
    d = obs_dat; s = obs_sat;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int          holdoff;
    int          period;
    logic [1:0]  trig;
    int          exp_r0;
    bit          exp_s0;
    int          exp_r1;
    bit          exp_s1;
    int          exp_lat;  // edges from the start edge to the edge after which done_o is high
  } vec_t;

  vec_t tbl [7];

  task automatic run_gate(input vec_t v);
    int lat;
    logic [CB-1:0] d;
    logic s;
    holdoff_i = HB'(v.holdoff); period_i = PB'(v.period); cont_i = 0;
    trig_i = v.trig; start_i = 1;
    step();
    start_i = 0;
    lat = 0;
    for (int j = 1; j <= 200; j++) begin
      step();
      if (obs_done) begin lat = j; break; end
    end
    chk("done_latency", lat, v.exp_lat);
    trig_i = '0;
    do_read(0, d, s);
    chk("res0", d, v.exp_r0);
    chk("sat0", s, v.exp_s0);
    do_read(1, d, s);
    chk("res1", d, v.exp_r1);
    chk("sat1", s, v.exp_s1);
    repeat (4) step();
  endtask

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1);
  end

  initial begin
    logic [CB-1:0] d;
    logic s;
    bit seen;

    // holdoff, period, trig, r0, s0, r1, s1, latency
    tbl[0] = '{0, 10, 2'b01, 10, 0, 0,  0, 11};
    tbl[1] = '{3, 20, 2'b10, 0,  0, 5,  0, 21};
    tbl[2] = '{0, 40, 2'b11, 15, 1, 15, 1, 41};
    tbl[3] = '{0, 8,  2'b00, 0,  0, 0,  0, 9};
    tbl[4] = '{0, 0,  2'b11, 1,  0, 1,  0, 2};
    tbl[5] = '{1, 9,  2'b01, 4,  0, 0,  0, 10};
    tbl[6] = '{2, 7,  2'b11, 2,  0, 2,  0, 8};

    do_reset();
    for (int i = 0; i < 7; i++) run_gate(tbl[i]);

    // Continuous gates of 5: done every 6 cycles; triggers only in SNAP are lost.
    holdoff_i = 0; period_i = 5; cont_i = 1; trig_i = '0; start_i = 1;
    step();
    start_i = 0;
    for (int j = 1; j <= 18; j++) begin
      trig_i = (j % 6 == 0) ? 2'b01 : 2'b00;
      step();
      chk("cont_done", obs_done, (j % 6 == 0));
    end
    trig_i = '0; abort_i = 1;
    step();
    abort_i = 0;
    do_read(0, d, s);
    chk("cont_snap_trig", {s, d}, 0);

    // Restart and abort mid-gate: bank must keep the previous gate's result.
    run_gate(tbl[0]);
    seen = 0;
    holdoff_i = 0; trig_i = 2'b01; period_i = 6; cont_i = 0; start_i = 1;
    step();
    start_i = 0;
    repeat (3) begin step(); seen |= obs_done; end
    start_i = 1;
    step();
    start_i = 0; seen |= obs_done;
    repeat (3) begin step(); seen |= obs_done; end
    abort_i = 1;
    step();
    abort_i = 0; seen |= obs_done;
    repeat (8) begin step(); seen |= obs_done; end
    chk("abort_no_done", seen, 0);
    do_read(0, d, s);
    chk("abort_keeps_bank", d, 10);

    // Read in the SNAP cycle returns old data; the back-to-back read sees the new one.
    period_i = 4; start_i = 1;
    step();
    start_i = 0;
    repeat (4) step();
    rd_stb_i = 1; rd_beam_i = 0;
    step();
    chk("snap_read_old", obs_dat, 10);
    chk("snap_done", obs_done, 1);
    step();
    rd_stb_i = 0; trig_i = '0;
    chk("b2b_read_new", obs_dat, 4);

    // Out-of-range beam reads as zero and is still acknowledged.
    do_read(NB, d, s);
    chk("oor_read", {s, d}, 0);
    do_read(255, d, s);
    chk("oor_read_255", {s, d}, 0);

    // Reset mid-gate: no done, bank cleared.
    trig_i = 2'b11; period_i = 30; start_i = 1;
    step();
    start_i = 0;
    repeat (5) step();
    do_reset();
    do_read(0, d, s);
    chk("reset_clears_bank", {s, d}, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      start_i   = ($urandom_range(0, 39) == 0);
      abort_i   = ($urandom_range(0, 99) == 0);
      period_i  = PB'($urandom_range(0, 12));
      cont_i    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) holdoff_i = HB'($urandom_range(0, 4));
      trig_i    = NB'($urandom_range(0, 3));
      rd_stb_i  = ($urandom_range(0, 3) == 0);
      rd_beam_i = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) do_reset();
      else                             step();
    end
    start_i = 0; abort_i = 0; rd_stb_i = 0; trig_i = '0;
    step();
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
